// File: rtl/floo_credit_link_tx.sv
// floo_credit_link_tx: registered credit-based egress stage between a router output port and the link
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   valid_i, data_i    flit offered by the router output port
//   ready_o            flit accepted this cycle (a credit is available)
//   link_valid_o/data  registered flit toward the neighbour's input FIFO
//   credit_i           one slot freed downstream this cycle
//   credit_cnt_o       credits currently available
//   idle_o             every credit is home
//   err_o              sticky credit-overflow flag
module floo_credit_link_tx #(
  parameter type         flit_t     = logic,
  parameter int unsigned NumCredits = 4,
  parameter int unsigned CntWidth   = $clog2(NumCredits + 1),
  parameter bit          OvfAssert  = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  output logic                ready_o,
  input  flit_t               data_i,
  output logic                link_valid_o,
  output flit_t               link_data_o,
  input  logic                credit_i,
  output logic [CntWidth-1:0] credit_cnt_o,
  output logic                idle_o,
  output logic                err_o
);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(NumCredits);

  if (NumCredits < 1) begin : g_bad_credits
    $fatal(1, "floo_credit_link_tx: NumCredits must be at least 1");
  end

  logic                send;
  logic                ovf;
  logic [CntWidth-1:0] cnt_d;

  // ready depends only on the counter register, so no combinational path crosses the link
  assign ready_o = credit_cnt_o != '0;
  assign idle_o  = credit_cnt_o == MaxCnt;
  assign send    = valid_i && ready_o;
  assign ovf     = credit_i && !send && idle_o;

  // a returned credit while all credits are home saturates instead of wrapping
  always_comb begin
    cnt_d = credit_cnt_o;
    if (send && !credit_i) cnt_d = credit_cnt_o - 1'b1;
    else if (credit_i && !send && !idle_o) cnt_d = credit_cnt_o + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      link_valid_o <= 1'b0;
      link_data_o  <= '0;
      credit_cnt_o <= MaxCnt;
      err_o        <= 1'b0;
    end else begin
      link_valid_o <= send;
      if (send) link_data_o <= data_i;
      credit_cnt_o <= cnt_d;
      if (ovf) err_o <= 1'b1;
    end
  end

  a_credit_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni) !(OvfAssert && ovf))
    else $error("floo_credit_link_tx: credit returned with all credits home");

  a_hold_flit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_i && !ready_o |=> valid_i && $stable(data_i))
    else $error("floo_credit_link_tx: flit withdrawn or changed while stalled");
endmodule

// File: tb/tb_floo_credit_link_tx.sv
// tb_floo_credit_link_tx: directed and random checks of floo_credit_link_tx against a credit-count model
module tb_floo_credit_link_tx;
  typedef logic [7:0] flit_t;
  localparam int NC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic       ready;
  flit_t      data = '0;
  logic       link_valid;
  flit_t      link_data;
  logic       credit = 1'b0;
  logic [2:0] credit_cnt;
  logic       idle;
  logic       err;

  int n_tests = 0;
  int n_fail = 0;

  int    m_cnt = NC;
  bit    m_lv = 0;
  bit    m_err = 0;
  flit_t m_ld = '0;

  floo_credit_link_tx #(.flit_t(flit_t), .NumCredits(NC), .OvfAssert(1'b0)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .valid_i(valid),
    .ready_o(ready),
    .data_i(data),
    .link_valid_o(link_valid),
    .link_data_o(link_data),
    .credit_i(credit),
    .credit_cnt_o(credit_cnt),
    .idle_o(idle),
    .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("cnt", 32'(credit_cnt), 32'(m_cnt));
    chk("ready", 32'(ready), 32'(m_cnt != 0));
    chk("idle", 32'(idle), 32'(m_cnt == NC));
    chk("link_valid", 32'(link_valid), 32'(m_lv));
    chk("link_data", 32'(link_data), 32'(m_ld));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic model_reset();
    m_cnt = NC;
    m_lv = 0;
    m_ld = '0;
    m_err = 0;
  endtask

  // one cycle: check the state left by the previous edge, then drive and predict the next
  task automatic cyc(input bit v, input flit_t d, input bit c);
    bit send;
    @(negedge clk);
    check_all();
    valid = v;
    data = d;
    credit = c;
    send = v && m_cnt != 0;
    m_lv = send;
    if (send) m_ld = d;
    if (c && !send) begin
      if (m_cnt == NC) m_err = 1;
      else m_cnt++;
    end else if (send && !c) m_cnt--;
  endtask

  initial begin
    bit    hold = 0;
    bit    v;
    bit    c;
    flit_t d = '0;
    #12 rst_n = 1'b1;
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    for (int i = 1; i <= 4; i++) cyc(1, flit_t'(8'hA0 + i), 0);
    cyc(1, 8'hA5, 0);
    cyc(1, 8'hA5, 0);
    cyc(1, 8'hA5, 1);
    cyc(1, 8'hA5, 0);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);
    cyc(1, 8'hB1, 1);
    cyc(1, 8'hB2, 1);
    cyc(1, 8'hB3, 1);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);
    cyc(1, 8'hC1, 0);
    cyc(0, 8'h00, 1);
    cyc(1, 8'hC2, 1);
    cyc(0, 8'h00, 0);
    for (int i = 1; i <= 3; i++) cyc(1, flit_t'(8'hD0 + i), 0);
    @(negedge clk);
    check_all();
    valid = 0;
    data = '0;
    credit = 0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 8'hE1, 0);
    cyc(0, 8'h00, 0);
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        v = ($urandom % 3) != 0;
        d = flit_t'($urandom);
      end
      c = m_cnt < NC && ($urandom % 2) == 1;
      hold = v && m_cnt == 0;
      cyc(v, d, c);
    end
    cyc(0, 8'h00, 0);
    @(negedge clk);
    check_all();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/floo_credit_link_tx.md
Name: floo_credit_link_tx

Overview:
- Egress link stage placed directly downstream of a router output port (one instance per output per physical channel: req, rsp, wide).
- Converts the router's valid/ready output handshake into a registered, credit-based link toward the neighbouring router's input FIFO.
- Removes the combinational ready path across the inter-tile link.
- Tracks free downstream buffer slots with a credit counter; credits are returned one per cycle by the receiver.

Parameters:
- flit_t, logic, flit type carried on the link (e.g. req/rsp/wide generic flit).
- NumCredits, 4, downstream input FIFO depth = initial credit count; must be >= 1 (elaboration assertion).
- CntWidth, $clog2(NumCredits+1), derived; credit counter width, not to be overridden.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  flit valid from router output port.
- ready_o  output  1  stage accepts flit (credit available).
- data_i  input  $bits(flit_t)  flit from router output port.
- link_valid_o  output  1  flit valid on link, registered.
- link_data_o  output  $bits(flit_t)  flit on link, registered.
- credit_i  input  1  one credit returned by downstream receiver this cycle.
- credit_cnt_o  output  CntWidth  current available credits.
- idle_o  output  1  all credits home (credit_cnt_o == NumCredits).
- err_o  output  1  sticky credit-overflow error.

Behaviour:
- Reset (async assert on rst_ni low, synchronous release semantics per flop):
  - link_valid_o=0, link_data_o=0, credit_cnt_o=NumCredits, idle_o=1, err_o=0.
- ready_o = (credit_cnt_o != 0). Purely registered source; no combinational path from valid_i or credit_i.
  - A credit returned in cycle N becomes usable in cycle N+1.
- Transfer: valid_i && ready_o at rising edge N gives link_valid_o=1 and link_data_o=data_i in cycle N+1. Latency exactly 1 cycle.
- No transfer in a cycle: link_valid_o=0 next cycle; link_data_o holds its last value (no toggling).
- Link has no backpressure: the receiver must accept every link_valid_o beat; credits guarantee space.
- Credit counter update per cycle (send = valid_i && ready_o):
  - send only: cnt-1.
  - credit_i only: cnt+1.
  - both: cnt unchanged.
  - neither: unchanged.
- Back-to-back: with credits available, one flit per cycle sustained; throughput 1 flit/cycle when round-trip credit latency <= NumCredits.
- Empty (cnt=0): ready_o=0; a valid_i held high is not lost, router holds data per valid/ready rule.
  - A credit arriving at cnt=0 re-enables ready_o next cycle.
- Overflow: credit_i while cnt==NumCredits and no send:
  - Counter saturates at NumCredits.
  - err_o set to 1 and held until reset.
  - Simulation assertion fires.
- Simultaneous credit_i and send at cnt==NumCredits is legal (net unchanged, no error).
- Underflow is impossible by construction (send requires cnt != 0).
- Reset mid-operation:
  - In-flight link flit dropped (link_valid_o=0).
  - Counter restored to NumCredits; receiver is reset in the same domain.
- idle_o = (cnt == NumCredits), combinational from counter register.
- valid_i must stay stable with data_i until accepted (protocol assertion: valid_i && !ready_o implies valid_i and data_i stable next cycle).

Test Plan:
- Reset, NumCredits=4, no traffic -> credit_cnt_o=4, ready_o=1, idle_o=1, link_valid_o=0, err_o=0.
- 4 back-to-back flits 0xA1..0xA4 with no credits returned:
  - link_valid_o high cycles 1-4 carrying 0xA1..0xA4.
  - credit_cnt_o 3,2,1,0.
  - ready_o=0 after 4th accept.
  - 5th flit 0xA5 held.
- From cnt=0 with 0xA5 pending, pulse credit_i at cycle N -> ready_o=1 at N+1, 0xA5 on link at N+2, cnt returns to 0.
- cnt=2, valid_i and credit_i high together for 3 cycles -> cnt stays 2, three flits emitted at 1/cycle.
- idle (cnt=4), pulse credit_i with no send -> cnt stays 4, err_o=1 and remains 1 after further traffic until rst_ni low.
- Assert rst_ni low mid-burst (cnt=1, link_valid_o=1) -> outputs immediately return to reset values, cnt=4 after release, next flit accepted in the first cycle.
